fpu_share_arbiter: RTL and testbench



---
 rtl/fpu_share_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// Shares one FPU APU slave port between NB_CORES cores. Arbitration is round-robin
// with a grant lock while the FPU stalls; responses are routed back by the returned ID.
module fpu_share_arbiter #(
  parameter int NB_CORES        = 4,
  parameter int NB_ARGS         = 3,
  parameter int OPCODE_WIDTH    = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int ID_WIDTH        = 9,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NB_CORES-1:0]                               core_req_i,
  output logic [NB_CORES-1:0]                               core_gnt_o,
  input  logic [NB_CORES-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0]  core_operands_i,
  input  logic [NB_CORES-1:0][OPCODE_WIDTH-1:0]             core_op_i,
  input  logic [NB_CORES-1:0][FLAGS_IN_WIDTH-1:0]           core_flags_i,
  output logic [NB_CORES-1:0]                               core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                             core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]                        core_rflags_o,
  output logic                                              fpu_req_o,
  input  logic                                              fpu_gnt_i,
  output logic [ID_WIDTH-1:0]                               fpu_ID_o,
  output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]                fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                           fpu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]                         fpu_flags_o,
  input  logic                                              fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                             fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]                        fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]                               fpu_rID_i,
  output logic                                              busy_o,
  output logic                                              err_o
);

  localparam int IDX_W = $clog2(NB_CORES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]                rr_ptr;
  logic [IDX_W-1:0]                lock_idx;
  logic                            locked;
  logic [NB_CORES-1:0][CNT_W-1:0]  cnt;
  logic [NB_CORES-1:0][CNT_W-1:0]  cnt_next;
  logic [NB_CORES-1:0]             eligible;
  logic [NB_CORES-1:0]             cnt_nz;
  logic [NB_CORES-1:0]             cnt_inc;
  logic [NB_CORES-1:0]             cnt_dec;
  logic [NB_CORES-1:0]             rsp_hit;
  logic [IDX_W:0]                  pick;
  logic [IDX_W-1:0]                winner;
  logic                            issue_req;
  logic                            handshake;
  logic                            lock_drop;
  logic                            id_ok;
  logic                            err_set;

  logic [NB_CORES-1:0]             rsp_vld_p1;
  logic [DATA_WIDTH-1:0]           rsp_data_p1;
  logic [FLAGS_OUT_WIDTH-1:0]      rsp_flags_p1;

  // Returns {found, index} of the first eligible core at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                             input logic [NB_CORES-1:0] elig);
    logic [IDX_W:0] res;
    int             j;
    res = '0;
    for (int k = NB_CORES - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NB_CORES;
      if (elig[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < NB_CORES; i++) begin
      cnt_nz[i]   = (cnt[i] != '0);
      eligible[i] = core_req_i[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Request stage (combinational issue)
  always_comb begin
    pick = rr_pick(rr_ptr, eligible);
    if (locked) begin
      winner    = lock_idx;
      issue_req = core_req_i[lock_idx];
    end else begin
      winner    = pick[IDX_W-1:0];
      issue_req = pick[IDX_W];
    end
  end

  assign handshake = issue_req && fpu_gnt_i;
  assign lock_drop = locked && !core_req_i[lock_idx];

  always_comb begin
    core_gnt_o     = '0;
    fpu_ID_o       = '0;
    fpu_operands_o = '0;
    fpu_op_o       = '0;
    fpu_flags_o    = '0;
    if (issue_req) begin
      core_gnt_o[winner] = fpu_gnt_i;
      fpu_ID_o           = ID_WIDTH'(winner);
      fpu_operands_o     = core_operands_i[winner];
      fpu_op_o           = core_op_i[winner];
      fpu_flags_o        = core_flags_i[winner];
    end
  end

  assign fpu_req_o = issue_req;

  // Out-of-range IDs never hit a core, so rsp_hit doubles as the one-hot route.
  assign id_ok = (fpu_rID_i < ID_WIDTH'(NB_CORES));

  always_comb begin
    cnt_next = cnt;
    for (int i = 0; i < NB_CORES; i++) begin
      rsp_hit[i] = fpu_rvalid_i && (fpu_rID_i == ID_WIDTH'(i));
      cnt_inc[i] = handshake && (winner == IDX_W'(i));
      cnt_dec[i] = rsp_hit[i] && cnt_nz[i];
      case ({cnt_inc[i], cnt_dec[i]})
        2'b10:   cnt_next[i] = cnt[i] + CNT_W'(1);
        2'b01:   cnt_next[i] = cnt[i] - CNT_W'(1);
        default: cnt_next[i] = cnt[i];
      endcase
    end
  end

  assign err_set = lock_drop || (fpu_rvalid_i && !id_ok) || (|(rsp_hit & ~cnt_nz));

  // Arbitration and bookkeeping state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      cnt      <= '0;
      err_o    <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (err_set) err_o <= 1'b1;
      if (handshake) begin
        rr_ptr <= (winner == IDX_W'(NB_CORES - 1)) ? '0 : winner + IDX_W'(1);
        locked <= 1'b0;
      end else if (lock_drop) begin
        locked <= 1'b0;
      end else if (issue_req) begin
        locked   <= 1'b1;
        lock_idx <= winner;
      end
    end
  end

  // Response stage p1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1   <= '0;
      rsp_data_p1  <= '0;
      rsp_flags_p1 <= '0;
    end else begin
      rsp_vld_p1 <= rsp_hit;
      if (fpu_rvalid_i && id_ok) begin
        rsp_data_p1  <= fpu_rdata_i;
        rsp_flags_p1 <= fpu_rflags_i;
      end
    end
  end

  assign core_rvalid_o = rsp_vld_p1;
  assign core_rdata_o  = rsp_data_p1;
  assign core_rflags_o = rsp_flags_p1;
  assign busy_o        = (|cnt_nz) || (|rsp_vld_p1);

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter: arbitration order, stall lock, outstanding
// limit, response routing, error flag and asynchronous reset.
module tb_fpu_share_arbiter;
  localparam int NC = 4, NA = 3, OW = 6, DW = 32, FIW = 15, FOW = 5, IW = 9, MO = 4;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NC-1:0]                 core_req;
  logic [NC-1:0]                 core_gnt;
  logic [NC-1:0][NA-1:0][DW-1:0] core_operands;
  logic [NC-1:0][OW-1:0]         core_op;
  logic [NC-1:0][FIW-1:0]        core_flags;
  logic [NC-1:0]                 core_rvalid;
  logic [DW-1:0]                 core_rdata;
  logic [FOW-1:0]                core_rflags;
  logic                          fpu_req;
  logic                          fpu_gnt;
  logic [IW-1:0]                 fpu_id;
  logic [NA-1:0][DW-1:0]         fpu_operands;
  logic [OW-1:0]                 fpu_op;
  logic [FIW-1:0]                fpu_flags;
  logic                          fpu_rvalid;
  logic [DW-1:0]                 fpu_rdata;
  logic [FOW-1:0]                fpu_rflags;
  logic [IW-1:0]                 fpu_rid;
  logic                          busy;
  logic                          err;

  int n_vec = 0;
  int n_err = 0;

  fpu_share_arbiter #(
    .NB_CORES(NC), .NB_ARGS(NA), .OPCODE_WIDTH(OW), .DATA_WIDTH(DW),
    .FLAGS_IN_WIDTH(FIW), .FLAGS_OUT_WIDTH(FOW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_gnt_o(core_gnt),
    .core_operands_i(core_operands), .core_op_i(core_op), .core_flags_i(core_flags),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_rflags_o(core_rflags),
    .fpu_req_o(fpu_req), .fpu_gnt_i(fpu_gnt), .fpu_ID_o(fpu_id),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_flags_o(fpu_flags),
    .fpu_rvalid_i(fpu_rvalid), .fpu_rdata_i(fpu_rdata), .fpu_rflags_i(fpu_rflags),
    .fpu_rID_i(fpu_rid), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    core_req   = '0;
    fpu_gnt    = 1'b0;
    fpu_rvalid = 1'b0;
    fpu_rdata  = '0;
    fpu_rflags = '0;
    fpu_rid    = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    #3;
    n_vec++; if (core_gnt !== 4'b0 || core_rvalid !== 4'b0) begin n_err++; $display("FAIL reset_grants gnt=%b rvalid=%b want 0/0", core_gnt, core_rvalid); end
    n_vec++; if (core_rdata !== 32'h0 || core_rflags !== 5'h0) begin n_err++; $display("FAIL reset_rdata rdata=%h rflags=%h want 0/0", core_rdata, core_rflags); end
    n_vec++; if (fpu_req !== 1'b0 || fpu_id !== 9'd0 || busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_ctrl req=%b id=%0d busy=%b err=%b want all 0", fpu_req, fpu_id, busy, err); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    core_req = 4'b0100; fpu_gnt = 1'b1; #2;
    n_vec++; if (fpu_req !== 1'b1 || fpu_id !== 9'd2) begin n_err++; $display("FAIL single_id req=%b id=%0d want 1/2", fpu_req, fpu_id); end
    n_vec++; if (core_gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b want 0100", core_gnt); end
    n_vec++; if (fpu_operands !== core_operands[2] || fpu_op !== 6'd12 || fpu_flags !== 15'd102) begin n_err++; $display("FAIL single_fields op=%0d flags=%0d want 12/102", fpu_op, fpu_flags); end
    tick();
    core_req = '0; fpu_gnt = 1'b0; #2;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
    fpu_rvalid = 1'b1; fpu_rid = 9'd2; fpu_rdata = 32'h3F800000; fpu_rflags = 5'h01;
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (core_rvalid !== 4'b0100 || core_rdata !== 32'h3F800000 || core_rflags !== 5'h01) begin n_err++; $display("FAIL single_resp rvalid=%b rdata=%h rflags=%h want 0100/3f800000/01", core_rvalid, core_rdata, core_rflags); end
    tick(); #2;
    n_vec++; if (core_rvalid !== 4'b0 || core_rdata !== 32'h3F800000 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle rvalid=%b rdata=%h busy=%b want 0/3f800000/0", core_rvalid, core_rdata, busy); end
  endtask

  task automatic test_contention;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NC-1:0] exp_gnt;
    do_reset();
    core_req = 4'b1111; fpu_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      exp_gnt = NC'(1) << order[k];
      n_vec++; if (core_gnt !== exp_gnt || fpu_id !== IW'(order[k])) begin n_err++; $display("FAIL rr_order step %0d gnt=%b id=%0d want %b/%0d", k, core_gnt, fpu_id, exp_gnt, order[k]); end
      tick();
    end
    core_req = '0; fpu_gnt = 1'b0;
  endtask

  task automatic test_stall_lock;
    do_reset();
    core_req = 4'b0001; fpu_gnt = 1'b1;
    tick();
    core_req = 4'b1010; fpu_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_vec++; if (fpu_id !== 9'd1 || core_gnt !== 4'b0 || fpu_req !== 1'b1) begin n_err++; $display("FAIL stall_hold cyc %0d id=%0d gnt=%b req=%b want 1/0000/1", k, fpu_id, core_gnt, fpu_req); end
      tick();
    end
    fpu_gnt = 1'b1; #2;
    n_vec++; if (core_gnt !== 4'b0010) begin n_err++; $display("FAIL stall_release gnt=%b want 0010", core_gnt); end
    tick();
    core_req = 4'b1000; #2;
    n_vec++; if (core_gnt !== 4'b1000 || fpu_id !== 9'd3) begin n_err++; $display("FAIL stall_next gnt=%b id=%0d want 1000/3", core_gnt, fpu_id); end
    tick();
    core_req = 4'b0010; fpu_gnt = 1'b0;
    tick();
    core_req = 4'b0011; #2;
    n_vec++; if (fpu_id !== 9'd1) begin n_err++; $display("FAIL lock_priority id=%0d want 1", fpu_id); end
    fpu_gnt = 1'b1; #2;
    n_vec++; if (core_gnt !== 4'b0010) begin n_err++; $display("FAIL lock_grant gnt=%b want 0010", core_gnt); end
    tick();
    core_req = '0; fpu_gnt = 1'b0;
  endtask

  task automatic test_outstanding;
    do_reset();
    core_req = 4'b0001; fpu_gnt = 1'b1;
    for (int k = 0; k < MO; k++) begin
      #2;
      n_vec++; if (core_gnt !== 4'b0001) begin n_err++; $display("FAIL limit_issue %0d gnt=%b want 0001", k, core_gnt); end
      tick();
    end
    #2;
    n_vec++; if (fpu_req !== 1'b0 || core_gnt !== 4'b0) begin n_err++; $display("FAIL limit_block req=%b gnt=%b want 0/0000", fpu_req, core_gnt); end
    core_req = 4'b0011; #2;
    n_vec++; if (core_gnt !== 4'b0010) begin n_err++; $display("FAIL limit_other gnt=%b want 0010", core_gnt); end
    tick();
    core_req = 4'b0001; fpu_rvalid = 1'b1; fpu_rid = 9'd0; #2;
    n_vec++; if (core_gnt !== 4'b0) begin n_err++; $display("FAIL limit_same_cycle gnt=%b want 0000", core_gnt); end
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (core_gnt !== 4'b0001) begin n_err++; $display("FAIL limit_reopen gnt=%b want 0001", core_gnt); end
    tick();
    core_req = '0; fpu_gnt = 1'b0;
  endtask

  task automatic test_simultaneous;
    do_reset();
    core_req = 4'b0001; fpu_gnt = 1'b1;
    tick();
    tick();
    fpu_rvalid = 1'b1; fpu_rid = 9'd0; fpu_rdata = 32'h0000AAAA; #2;
    n_vec++; if (core_gnt !== 4'b0001) begin n_err++; $display("FAIL simul_gnt gnt=%b want 0001", core_gnt); end
    tick();
    core_req = '0; fpu_gnt = 1'b0;
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (core_rvalid !== 4'b0001) begin n_err++; $display("FAIL simul_resp rvalid=%b want 0001", core_rvalid); end
    tick(); #2;
    n_vec++; if (busy !== 1'b1 || core_rvalid !== 4'b0) begin n_err++; $display("FAIL simul_busy_mid busy=%b rvalid=%b want 1/0000", busy, core_rvalid); end
    fpu_rvalid = 1'b1; fpu_rid = 9'd0;
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (busy !== 1'b1 || core_rvalid !== 4'b0001) begin n_err++; $display("FAIL simul_last busy=%b rvalid=%b want 1/0001", busy, core_rvalid); end
    tick(); #2;
    n_vec++; if (busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL simul_idle busy=%b err=%b want 0/0", busy, err); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    core_req = 4'b0110; fpu_gnt = 1'b1; #2;
    n_vec++; if (core_gnt !== 4'b0010) begin n_err++; $display("FAIL b2b_gnt1 gnt=%b want 0010", core_gnt); end
    tick(); #2;
    n_vec++; if (core_gnt !== 4'b0100) begin n_err++; $display("FAIL b2b_gnt2 gnt=%b want 0100", core_gnt); end
    tick();
    core_req = '0; fpu_gnt = 1'b0;
    fpu_rvalid = 1'b1; fpu_rid = 9'd1; fpu_rdata = 32'h11111111; fpu_rflags = 5'h02;
    tick();
    fpu_rid = 9'd2; fpu_rdata = 32'h22222222; fpu_rflags = 5'h04; #2;
    n_vec++; if (core_rvalid !== 4'b0010 || core_rdata !== 32'h11111111 || core_rflags !== 5'h02) begin n_err++; $display("FAIL b2b_resp1 rvalid=%b rdata=%h rflags=%h want 0010/11111111/02", core_rvalid, core_rdata, core_rflags); end
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (core_rvalid !== 4'b0100 || core_rdata !== 32'h22222222 || core_rflags !== 5'h04) begin n_err++; $display("FAIL b2b_resp2 rvalid=%b rdata=%h rflags=%h want 0100/22222222/04", core_rvalid, core_rdata, core_rflags); end
    tick(); #2;
    n_vec++; if (core_rvalid !== 4'b0 || core_rdata !== 32'h22222222 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_hold rvalid=%b rdata=%h busy=%b want 0/22222222/0", core_rvalid, core_rdata, busy); end
  endtask

  task automatic test_errors;
    do_reset(); #2;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_init got %b want 0", err); end
    fpu_rvalid = 1'b1; fpu_rid = 9'd7; fpu_rdata = 32'hDEADBEEF;
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (core_rvalid !== 4'b0 || err !== 1'b1 || core_rdata !== 32'h0) begin n_err++; $display("FAIL err_bad_id rvalid=%b err=%b rdata=%h want 0000/1/0", core_rvalid, err, core_rdata); end
    core_req = 4'b0001; fpu_gnt = 1'b1;
    tick(); tick(); tick();
    core_req = '0; fpu_gnt = 1'b0;
    fpu_rvalid = 1'b1; fpu_rid = 9'd0; fpu_rdata = 32'h12345678; fpu_rflags = 5'h1F;
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (core_rvalid !== 4'b0001 || busy !== 1'b1) begin n_err++; $display("FAIL err_pre_reset rvalid=%b busy=%b want 0001/1", core_rvalid, busy); end
    rst_n = 1'b0; #1;
    n_vec++; if (core_rvalid !== 4'b0 || core_rdata !== 32'h0 || core_rflags !== 5'h0) begin n_err++; $display("FAIL async_reset_resp rvalid=%b rdata=%h rflags=%h want 0", core_rvalid, core_rdata, core_rflags); end
    n_vec++; if (err !== 1'b0 || busy !== 1'b0 || fpu_req !== 1'b0 || core_gnt !== 4'b0) begin n_err++; $display("FAIL async_reset_ctrl err=%b busy=%b req=%b gnt=%b want 0", err, busy, fpu_req, core_gnt); end
    tick(); tick();
    rst_n = 1'b1;
    fpu_rvalid = 1'b1; fpu_rid = 9'd0; fpu_rdata = 32'h00000055;
    tick();
    fpu_rvalid = 1'b0; #2;
    n_vec++; if (core_rvalid !== 4'b0001 || err !== 1'b1 || core_rdata !== 32'h55) begin n_err++; $display("FAIL err_cnt_zero rvalid=%b err=%b rdata=%h want 0001/1/55", core_rvalid, err, core_rdata); end
    tick(); #2;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL err_cnt_stays0 busy=%b want 0", busy); end
  endtask

  task automatic test_lock_drop;
    do_reset();
    core_req = 4'b0100; fpu_gnt = 1'b0;
    tick();
    core_req = '0; #2;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL drop_before err=%b want 0", err); end
    tick(); #2;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL drop_err err=%b want 1", err); end
    core_req = 4'b0001; fpu_gnt = 1'b1; #2;
    n_vec++; if (core_gnt !== 4'b0001) begin n_err++; $display("FAIL drop_unlock gnt=%b want 0001", core_gnt); end
    tick();
    core_req = '0; fpu_gnt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin
      for (int a = 0; a < NA; a++) core_operands[i][a] = DW'(32'h10000000 * (i + 1) + a + 1);
      core_op[i]    = OW'(10 + i);
      core_flags[i] = FIW'(100 + i);
    end
    test_reset();
    test_single();
    test_contention();
    test_stall_lock();
    test_outstanding();
    test_simultaneous();
    test_back_to_back();
    test_errors();
    test_lock_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
